fir_tap: RTL and testbench

FIR_TAP -- requirements
Module: fir_tap

---
 rtl/fir_pkg.sv | 15 +
 rtl/fir_tap_mac.sv | 54 +++++
 rtl/fir_tap.sv | 49 ++++
 tb/tb_fir_tap.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared widths, coefficient type and saturation bounds for the FIR tap chain.
// The clamp constants apply at the default accumulator width.
package fir_pkg;

    localparam int COEFF_WIDTH_DEF = 8;
    localparam int DATA_WIDTH_DEF  = 32;
    localparam int ACC_WIDTH_DEF   = 32;
    localparam int NUM_COEFFS      = 15;

    typedef logic signed [COEFF_WIDTH_DEF-1:0] coeff_t;

    localparam logic [ACC_WIDTH_DEF-1:0] SAT_MAX = {1'b0, {(ACC_WIDTH_DEF-1){1'b1}}};
    localparam logic [ACC_WIDTH_DEF-1:0] SAT_MIN = {1'b1, {(ACC_WIDTH_DEF-1){1'b0}}};

endpackage

// File: rtl/fir_tap_mac.sv
// Combinational multiply-add for one transposed FIR tap: coeff*data + prev.
// Clamping to the accumulator range is built only when FIR_TAP_SATURATE_EN is defined.
module fir_tap_mac
    import fir_pkg::*;
#(
    parameter int C_S00_AXIS_TDATA_WIDTH = DATA_WIDTH_DEF,
    parameter int C_M00_AXIS_TDATA_WIDTH = ACC_WIDTH_DEF,
    parameter int COEFF_WIDTH            = COEFF_WIDTH_DEF
) (
    input  logic [COEFF_WIDTH-1:0]            coeff_in,
    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0] data_in,
    input  logic [C_M00_AXIS_TDATA_WIDTH-1:0] prev_in,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0] sum_out
);

    localparam int DW = C_S00_AXIS_TDATA_WIDTH;
    localparam int OW = C_M00_AXIS_TDATA_WIDTH;
    localparam int CW = COEFF_WIDTH;
    localparam int PW = CW + DW;
    localparam int SW = ((PW > OW) ? PW : OW) + 1;

    logic [PW-1:0]        coeff_ext;
    logic [PW-1:0]        data_ext;
    logic [PW-1:0]        prod;
    logic signed [SW-1:0] sum;

    // Low PW bits of the product of sign-extended operands equal the signed product.
    assign coeff_ext = {{DW{coeff_in[CW-1]}}, coeff_in};
    assign data_ext  = {{CW{data_in[DW-1]}}, data_in};
    assign prod      = coeff_ext * data_ext;
    assign sum       = $signed({{(SW-PW){prod[PW-1]}}, prod})
                     + $signed({{(SW-OW){prev_in[OW-1]}}, prev_in});

`ifdef FIR_TAP_SATURATE_EN
    localparam logic signed [SW-1:0] SAT_HI = {{(SW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_LO = {{(SW-OW+1){1'b1}}, {(OW-1){1'b0}}};

    always_comb begin
        sum_out = sum[OW-1:0];
        if (sum > SAT_HI) begin
            sum_out = SAT_HI[OW-1:0];
        end else if (sum < SAT_LO) begin
            sum_out = SAT_LO[OW-1:0];
        end
    end
`else
    logic sum_hi_unused;

    // Two's-complement wrap: the bits above the accumulator width are dropped.
    assign sum_out       = sum[OW-1:0];
    assign sum_hi_unused = ^sum[SW-1:OW];
`endif

endmodule

// File: rtl/fir_tap.sv
// One transposed-form FIR tap stage with ready-gated output registers.
// Define FIR_TAP_SATURATE_EN to clamp the sum instead of wrapping it.
module fir_tap
    import fir_pkg::*;
#(
    parameter int C_S00_AXIS_TDATA_WIDTH = DATA_WIDTH_DEF,
    parameter int C_M00_AXIS_TDATA_WIDTH = ACC_WIDTH_DEF,
    parameter int COEFF_WIDTH            = COEFF_WIDTH_DEF
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              ready,
    input  logic                              valid_in,
    input  logic                              last_in,
    input  logic [COEFF_WIDTH-1:0]            coeff_in,
    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0] data_in,
    input  logic [C_M00_AXIS_TDATA_WIDTH-1:0] prev_in,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0] data_out,
    output logic                              valid_out,
    output logic                              last_out
);

    logic [C_M00_AXIS_TDATA_WIDTH-1:0] mac_sum;

    fir_tap_mac #(
        .C_S00_AXIS_TDATA_WIDTH(C_S00_AXIS_TDATA_WIDTH),
        .C_M00_AXIS_TDATA_WIDTH(C_M00_AXIS_TDATA_WIDTH),
        .COEFF_WIDTH           (COEFF_WIDTH)
    ) u_mac (
        .coeff_in(coeff_in),
        .data_in (data_in),
        .prev_in (prev_in),
        .sum_out (mac_sum)
    );

    // Valid does not gate the update; the parent zeroes data_in for bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out  <= '0;
            valid_out <= 1'b0;
            last_out  <= 1'b0;
        end else if (ready) begin
            data_out  <= mac_sum;
            valid_out <= valid_in;
            last_out  <= last_in;
        end
    end

endmodule

// File: tb/tb_fir_tap.sv
// Directed self-checking bench for fir_tap; expectations follow FIR_TAP_SATURATE_EN.
`timescale 1ns/1ps
module tb_fir_tap;
    import fir_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        ready;
    logic        valid_in;
    logic        last_in;
    logic [7:0]  coeff_in;
    logic [31:0] data_in;
    logic [31:0] prev_in;
    logic [31:0] data_out;
    logic        valid_out;
    logic        last_out;

    int checks = 0;
    int errors = 0;

    fir_tap dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ready    (ready),
        .valid_in (valid_in),
        .last_in  (last_in),
        .coeff_in (coeff_in),
        .data_in  (data_in),
        .prev_in  (prev_in),
        .data_out (data_out),
        .valid_out(valid_out),
        .last_out (last_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] d, input logic v, input logic l);
        check({tag, "_data"},  data_out,  d);
        check({tag, "_valid"}, {31'd0, valid_out}, {31'd0, v});
        check({tag, "_last"},  {31'd0, last_out},  {31'd0, l});
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        ready    = 1'b1;
        valid_in = 1'b1;
        last_in  = 1'b0;
        coeff_in = 8'd1;
        data_in  = 32'd5;
        prev_in  = 32'd0;

        #2;
        check_all("reset_no_edge", 32'd0, 1'b0, 1'b0);
        cycle();
        cycle();
        check_all("reset_held_ready", 32'd0, 1'b0, 1'b0);

        @(negedge clk);
        rst_n = 1'b1;
        ready = 1'b0;
        cycle();
        check_all("post_reset_stall", 32'd0, 1'b0, 1'b0);

        ready    = 1'b1;
        coeff_in = 8'hFE;
        data_in  = 32'd100;
        prev_in  = 32'd50;
        valid_in = 1'b1;
        cycle();
        check_all("basic_mac", 32'hFFFF_FF6A, 1'b1, 1'b0);

        ready   = 1'b0;
        data_in = 32'd7;
        prev_in = 32'd9;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check_all("stall_hold", 32'hFFFF_FF6A, 1'b1, 1'b0);
        end

        ready = 1'b1;
        cycle();
        check_all("stall_release", 32'hFFFF_FFFB, 1'b1, 1'b0);

        coeff_in = 8'd3;
        data_in  = 32'hFFFF_FFFC;
        prev_in  = 32'd1000;
        last_in  = 1'b1;
        cycle();
        check_all("last_set", 32'd988, 1'b1, 1'b1);
        last_in = 1'b0;
        cycle();
        check_all("last_clear", 32'd988, 1'b1, 1'b0);

        valid_in = 1'b0;
        last_in  = 1'b1;
        cycle();
        check_all("last_without_valid", 32'd988, 1'b0, 1'b1);
        valid_in = 1'b1;
        last_in  = 1'b0;

        coeff_in = 8'd2;
        data_in  = 32'h7FFF_FFFF;
        prev_in  = 32'd0;
        cycle();
`ifdef FIR_TAP_SATURATE_EN
        check("overflow_pos", data_out, SAT_MAX);
`else
        check("overflow_pos", data_out, 32'hFFFF_FFFE);
`endif

        coeff_in = 8'h80;
        data_in  = 32'h8000_0000;
        cycle();
`ifdef FIR_TAP_SATURATE_EN
        check("overflow_big_pos", data_out, 32'h7FFF_FFFF);
`else
        check("overflow_big_pos", data_out, 32'h0000_0000);
`endif

        coeff_in = 8'd1;
        data_in  = 32'h8000_0000;
        prev_in  = 32'h8000_0000;
        cycle();
`ifdef FIR_TAP_SATURATE_EN
        check("overflow_neg", data_out, SAT_MIN);
`else
        check("overflow_neg", data_out, 32'h0000_0000);
`endif

        data_in = 32'd1;
        prev_in = 32'd0;
        cycle();
        check_all("pre_async", 32'd1, 1'b1, 1'b0);

        ready = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        check_all("async_reset", 32'd0, 1'b0, 1'b0);
        ready = 1'b1;
        cycle();
        check_all("async_reset_held", 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
        check_all("after_async", 32'd1, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
